// File: rtl/rhd_headstage_emulator.sv
// Cycle-accurate RHD-style headstage SPI slave: oversampled CS/SCLK/MOSI, 16-bit command
// decode, and a two-frame response pipeline driven out on MISO.
`timescale 1ns/1ps
module rhd_headstage_emulator #(
    parameter int NUM_CHANNELS  = 32,
    parameter int STARTING_SEED = 0,
    parameter int SEED_STRIDE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        cmd_valid,
    output logic [15:0] cmd_word,
    output logic        frame_abort,
    output logic [15:0] frame_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;
    localparam int         NUM_REGS = 22;

    function automatic logic [15:0] seed_of(input int c);
        seed_of = 16'(STARTING_SEED + c * SEED_STRIDE);
    endfunction

    function automatic logic [7:0] rom_byte(input logic [5:0] a);
        case (a)
            6'd40:   rom_byte = 8'h49;
            6'd41:   rom_byte = 8'h4E;
            6'd42:   rom_byte = 8'h54;
            6'd43:   rom_byte = 8'h41;
            6'd44:   rom_byte = 8'h4E;
            6'd60:   rom_byte = 8'h01;
            6'd63:   rom_byte = 8'h01;
            default: rom_byte = 8'h00;
        endcase
    endfunction

    // Stage [0] is the metastability flop, [1] the synchronized value, [2] its previous value.
    logic [2:0]  cs_pipe_q, cs_pipe_d, sclk_pipe_q, sclk_pipe_d;
    logic [1:0]  mosi_pipe_q, mosi_pipe_d;
    logic [1:0]  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_q, rx_d, tx_q, tx_d;
    logic        miso_q, miso_d, cmd_valid_q, cmd_valid_d, frame_abort_q, frame_abort_d;
    logic [15:0] cmd_word_q, cmd_word_d, frame_count_q, frame_count_d;
    logic [15:0] slot0_q, slot0_d, slot1_q, slot1_d;
    logic [15:0] cnt_q [NUM_CHANNELS];
    logic [15:0] cnt_d [NUM_CHANNELS];
    logic [7:0]  regf_q [NUM_REGS];
    logic [7:0]  regf_d [NUM_REGS];

    logic        cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s, mosi_s;
    logic [5:0]  sel_s;
    logic [15:0] cnt_rd_s, resp_s;
    logic [7:0]  reg_rd_s;

    assign cs_fall_s   = cs_pipe_q[2] & ~cs_pipe_q[1];
    assign cs_rise_s   = ~cs_pipe_q[2] & cs_pipe_q[1];
    assign sclk_rise_s = ~sclk_pipe_q[2] & sclk_pipe_q[1];
    assign sclk_fall_s = sclk_pipe_q[2] & ~sclk_pipe_q[1];
    assign mosi_s      = mosi_pipe_q[1];
    assign sel_s       = rx_q[13:8];

    // Channel counter and register lookups addressed by the received word.
    always_comb begin
        cnt_rd_s = 16'h0000;
        reg_rd_s = 8'h00;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            cnt_rd_s = cnt_rd_s | ((int'(sel_s) == i) ? cnt_q[i] : 16'h0000);
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_rd_s = reg_rd_s | ((int'(sel_s) == i) ? regf_q[i] : 8'h00);
        end
    end

    // Frame FSM, shift registers, decode and response pipeline next-state.
    always_comb begin
        cs_pipe_d     = {cs_pipe_q[1:0], CS};
        sclk_pipe_d   = {sclk_pipe_q[1:0], SCLK};
        mosi_pipe_d   = {mosi_pipe_q[0], MOSI};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        rx_d          = rx_q;
        tx_d          = tx_q;
        miso_d        = miso_q;
        cmd_valid_d   = 1'b0;
        frame_abort_d = 1'b0;
        cmd_word_d    = cmd_word_q;
        frame_count_d = frame_count_q;
        slot0_d       = slot0_q;
        slot1_d       = slot1_q;
        cnt_d         = cnt_q;
        regf_d        = regf_q;
        resp_s        = 16'h0000;
        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 5'd0;
                    rx_d      = 16'h0000;
                    miso_d    = slot0_q[15];
                    tx_d      = {slot0_q[14:0], 1'b0};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_d       = ST_IDLE;
                    miso_d        = 1'b0;
                    frame_abort_d = 1'b1;
                end else if (sclk_rise_s) begin
                    rx_d      = {rx_q[14:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    state_d   = (bit_cnt_q == 5'd15) ? ST_DONE : ST_SHIFT;
                end else if (sclk_fall_s) begin
                    miso_d = tx_q[15];
                    tx_d   = {tx_q[14:0], 1'b0};
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (cs_rise_s) begin
                    state_d       = ST_IDLE;
                    miso_d        = 1'b0;
                    cmd_valid_d   = 1'b1;
                    cmd_word_d    = rx_q;
                    frame_count_d = frame_count_q + 16'd1;
                    case (rx_q[15:14])
                        2'b00: begin
                            resp_s = cnt_rd_s;
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                cnt_d[i] = (int'(sel_s) == i) ? cnt_q[i] + 16'd1 : cnt_q[i];
                            end
                        end
                        2'b01: begin
                            resp_s = 16'h0000;
                            for (int i = 0; i < NUM_CHANNELS; i++) begin
                                cnt_d[i] = (rx_q == 16'h6A00) ? seed_of(i) : cnt_q[i];
                            end
                        end
                        2'b10: begin
                            resp_s = (sel_s <= 6'd21) ? {8'hFF, rx_q[7:0]} : 16'hFF00;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                regf_d[i] = (int'(sel_s) == i) ? rx_q[7:0] : regf_q[i];
                            end
                        end
                        2'b11: begin
                            resp_s = (sel_s <= 6'd21) ? {8'h00, reg_rd_s} : {8'h00, rom_byte(sel_s)};
                        end
                        default: begin
                            resp_s = 16'h0000;
                        end
                    endcase
                    slot0_d = slot1_q;
                    slot1_d = resp_s;
                end else if (sclk_fall_s) begin
                    miso_d = tx_q[15];
                    tx_d   = {tx_q[14:0], 1'b0};
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset clears everything and reloads the channel seeds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_pipe_q     <= 3'b000;
            sclk_pipe_q   <= 3'b000;
            mosi_pipe_q   <= 2'b00;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 5'd0;
            rx_q          <= 16'h0000;
            tx_q          <= 16'h0000;
            miso_q        <= 1'b0;
            cmd_valid_q   <= 1'b0;
            frame_abort_q <= 1'b0;
            cmd_word_q    <= 16'h0000;
            frame_count_q <= 16'h0000;
            slot0_q       <= 16'h0000;
            slot1_q       <= 16'h0000;
            for (int i = 0; i < NUM_CHANNELS; i++) cnt_q[i] <= seed_of(i);
            for (int i = 0; i < NUM_REGS; i++) regf_q[i] <= 8'h00;
        end else begin
            cs_pipe_q     <= cs_pipe_d;
            sclk_pipe_q   <= sclk_pipe_d;
            mosi_pipe_q   <= mosi_pipe_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            miso_q        <= miso_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_abort_q <= frame_abort_d;
            cmd_word_q    <= cmd_word_d;
            frame_count_q <= frame_count_d;
            slot0_q       <= slot0_d;
            slot1_q       <= slot1_d;
            cnt_q         <= cnt_d;
            regf_q        <= regf_d;
        end
    end

    assign MISO        = miso_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_word    = cmd_word_q;
    assign frame_abort = frame_abort_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/rhd_headstage_emulator.md
# rhd_headstage_emulator

Parametrised, cycle-accurate bench and bring-up model of an RHD-style headstage SPI slave, running synchronously in the `clk` domain. It oversamples the controller's `CS`/`SCLK`/`MOSI`, decodes 16-bit CONVERT/READ/WRITE/CALIBRATE commands, and returns results on `MISO` with the two-frame pipeline latency of the real chip. It replaces the free-running counter slave in headstage-controller testbenches. It also serves as a loopback target in the HWU FPGA image.

## Interface
- NUM_CHANNELS, 32, number of emulated amplifier channels (1..64)
- STARTING_SEED, 0, initial counter value of channel 0
- SEED_STRIDE, 1, per-channel seed offset: channel c resets to STARTING_SEED + c*SEED_STRIDE (mod 2^16)
- clk  input  1  system clock; must be ≥ 8× SCLK frequency
- rst  input  1  reset, asynchronous, active-high
- CS  input  1  SPI chip select, active-low, asynchronous to clk
- SCLK  input  1  SPI clock, idle low, asynchronous to clk
- MOSI  input  1  SPI data in, MSB first
- MISO  output  1  SPI data out, MSB first
- cmd_valid  output  1  one-cycle pulse when a complete 16-bit command is decoded
- cmd_word  output  16  last complete command, valid with cmd_valid
- frame_abort  output  1  one-cycle pulse when CS deasserts with fewer than 16 bits received
- frame_count  output  16  count of complete frames, wraps at 2^16

## Operation
- CS, SCLK, and MOSI each pass through 2-flop synchronizers. Edges are detected on the synchronized signals.
- States:
  - IDLE: CS high.
  - SHIFT: CS low, bit counter 0..16.
  - DONE: 16 bits received, waiting for CS to rise.
- IDLE→SHIFT on CS fall. At that point, load the transmit shift register from pipeline slot 0 and drive its MSB on MISO.
- In SHIFT, each SCLK rising edge shifts MOSI into rx[0], with the word shifted left. The 16th rising edge moves the FSM to DONE.
- Each SCLK falling edge in SHIFT advances MISO to the next tx bit. Falling edges after bit 15 hold MISO at 0.
- DONE→IDLE on CS rise. On that transition:
  - decode rx;
  - pulse cmd_valid;
  - increment frame_count;
  - push the response into slot 1, with slot 1 moving to slot 0.
- SHIFT→IDLE on CS rise with fewer than 16 bits received:
  - pulse frame_abort;
  - the pipeline, counters, and registers are unchanged.
- SCLK edges while CS is high are ignored.
- Decode of rx[15:0]:
  - CONVERT 00cccccc_xxxxxxxx:
    - If c < NUM_CHANNELS, the response is counter[c], then counter[c] increments, wrapping at 2^16.
    - Otherwise the response is 16'h0000 and no counter changes.
  - CALIBRATE 01010101_00000000: response 16'h0000.
  - CLEAR 01101010_00000000: response 16'h0000, and all channel counters reload their seeds.
  - WRITE 10aaaaaa_dddddddd: if a ≤ 21, reg[a] ← d. Response is {8'hFF, reg[a] after the write}; for an unwritable a, the response is {8'hFF, 8'h00}.
  - READ 11aaaaaa_xxxxxxxx: response is {8'h00, value}.
    - a = 0..21: value is reg[a].
    - a = 40..44: value is ASCII "INTAN", with a=40 → 8'h49.
    - a = 60: 8'h01.
    - a = 63: 8'h01.
    - All other addresses: 8'h00.
  - Any other 01-prefixed word: response 16'h0000.
- The register file is 22×8. Reset value is 0.

## Timing
- Reset values:
  - MISO=0, cmd_valid=0, frame_abort=0, frame_count=0, cmd_word=0;
  - FSM in IDLE;
  - pipeline slots 0 and 1 both 16'h0000;
  - counters at their seeds.
- MISO is 0 whenever CS (synchronized) is high.
- Synchronizer latency is 2 clk. MISO's MSB appears 3 clk after the CS pin falls. Each subsequent bit appears 3 clk after the corresponding SCLK pin falls.
- Response latency: the response to the command in frame n is shifted out during frame n+2.
- cmd_valid and frame_abort are asserted 3 clk after the CS pin rises, and each lasts exactly 1 clk.
- If rst asserts mid-frame, all state is cleared immediately. The frame in progress is dropped, and the first frame after reset returns 16'h0000.
- If a CS fall and an SCLK rise are synchronized in the same clk, the SCLK edge is ignored.

## Test plan
- Reset, then send 3 complete frames → MISO words are 0000, 0000, then the response to frame 1. frame_count=3.
- NUM_CHANNELS=32, STARTING_SEED=100, SEED_STRIDE=1. Send CONVERT ch5 four times, then 2 dummy frames → responses 105, 106, 107, 108 appear in frames 3..6.
- WRITE reg3=0xA5, then READ reg3, then 2 dummies → frame 3 returns 0xFFA5 and frame 4 returns 0x00A5. READ 40..44 returns 0x0049, 0x004E, 0x0054, 0x0041, 0x004E.
- CONVERT ch40 (NUM_CHANNELS=32) → response 0x0000, and ch40 wrap logic is untouched. CONVERT ch0 with counter=0xFFFF → response 0xFFFF, and the next CONVERT ch0 returns 0x0000.
- CS raised after 9 SCLK cycles → one frame_abort pulse, no cmd_valid, frame_count unchanged, pipeline not advanced.
- rst pulsed mid-frame during bit 7 → MISO=0 immediately. The next two frames return 0x0000, and counters are back at their seeds.
